// File: rtl/riscv_fetch_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Holds the fetch FSM state type, the FIFO entry layout and the opcode-width decode.
package riscv_fetch_prefetch_queue_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_GNT     = 2'd1,
    WAIT_RVALID  = 2'd2,
    WAIT_ABORTED = 2'd3
  } fetch_state_t;

  localparam logic [1:0]  C_OPCODE_32B = 2'b11;
  localparam logic [31:0] WORD_BYTES   = 32'd4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rdata;
  } fifo_entry_t;

  // Low opcode bits 2'b11 mark a full 32-bit instruction.
  function automatic logic is_32b(input logic [1:0] op);
    return (op == C_OPCODE_32B);
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Shift-down word FIFO for the prefetch queue; entry 0 is always the head.
// Exposes head and next entries so the top can realign across word boundaries.
module riscv_fetch_fifo
  import riscv_fetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fifo_entry_t   push_data,
  output fifo_entry_t   head,
  output fifo_entry_t   next,
  output logic          head_valid,
  output logic          next_valid,
  output logic [CW-1:0] count
);

  localparam int IW = $clog2(DEPTH);

  fifo_entry_t   mem_r [DEPTH];
  logic [CW-1:0] count_r;
  logic          do_pop_s;
  logic          do_push_s;
  logic [IW-1:0] wr_idx_s;

  // Qualify push/pop against occupancy and pick the write slot after any shift.
  always_comb begin
    do_pop_s  = pop & (count_r != '0);
    do_push_s = push & ((count_r < CW'(DEPTH)) | do_pop_s);
    if (do_pop_s) begin
      wr_idx_s = IW'(count_r - CW'(1));
    end else begin
      wr_idx_s = IW'(count_r);
    end
  end

  // Storage and occupancy; flush only needs to clear the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      count_r <= '0;
    end else begin
      if (do_pop_s) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem_r[i] <= mem_r[i + 1];
        end
      end
      if (do_push_s) begin
        mem_r[wr_idx_s] <= push_data;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head       = mem_r[0];
  assign next       = mem_r[1];
  assign head_valid = (count_r != '0);
  assign next_valid = (count_r > CW'(1));
  assign count      = count_r;

endmodule

// File: rtl/riscv_fetch_prefetch_queue.sv
// Instruction prefetch queue: word fetch over req/gnt/rvalid, halfword realignment,
// branch and hardware-loop redirects, one instruction at a time to the fetch stage.
module riscv_fetch_prefetch_queue
  import riscv_fetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        hwloop_i,
  input  logic [31:0] hwloop_target_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        is_hwlp_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state_r, state_nxt_s;
  logic [31:0]   fetch_addr_r, fetch_addr_nxt_s;
  logic [31:0]   pc_r, pc_nxt_s;
  logic          is_hwlp_r, is_hwlp_nxt_s;

  fifo_entry_t   head_s, next_s, push_entry_s;
  logic          head_valid_s, next_valid_s;
  logic [CW-1:0] count_s, occ_s;

  logic          valid_s, consume_s, hwlp_take_s, redirect_s;
  logic          pop_s, push_s, space_s, req_s;
  logic [31:0]   rdata_s, target_s;
  logic          unused_addr_s;

  assign push_entry_s = '{addr: fetch_addr_r, rdata: instr_rdata_i};

  riscv_fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .pop        (pop_s),
    .flush      (redirect_s),
    .push_data  (push_entry_s),
    .head       (head_s),
    .next       (next_s),
    .head_valid (head_valid_s),
    .next_valid (next_valid_s),
    .count      (count_s)
  );

  // Entry addresses travel with the data for debug visibility only.
  assign unused_addr_s = ^{head_s.addr, next_s.addr};

  // Realign the instruction starting at pc_r from the head (and next) word.
  always_comb begin
    valid_s = 1'b0;
    rdata_s = head_s.rdata;
    if (!pc_r[1]) begin
      valid_s = head_valid_s;
      rdata_s = head_s.rdata;
    end else if (!is_32b(head_s.rdata[17:16])) begin
      valid_s = head_valid_s;
      rdata_s = {16'h0000, head_s.rdata[31:16]};
    end else begin
      valid_s = head_valid_s & next_valid_s;
      rdata_s = {next_s.rdata[15:0], head_s.rdata[31:16]};
    end
  end

  assign valid_o = valid_s & ~branch_i;

  // Handshake, redirect selection and FIFO push/pop with lookahead occupancy.
  always_comb begin
    consume_s   = valid_o & ready_i;
    hwlp_take_s = consume_s & hwloop_i;
    redirect_s  = branch_i | hwlp_take_s;
    if (branch_i) begin
      target_s = addr_i;
    end else begin
      target_s = hwloop_target_i;
    end
    pop_s  = consume_s & (pc_r[1] | is_32b(rdata_s[1:0]));
    push_s = instr_rvalid_i & (state_r == WAIT_RVALID) & ~redirect_s;
    // Space must hold after this cycle's push/pop, since the new word lands later.
    occ_s  = count_s + CW'(push_s) - CW'(pop_s);
    if (redirect_s) begin
      space_s = 1'b1;
    end else begin
      space_s = (occ_s < CW'(DEPTH));
    end
  end

  // Fetch FSM next state and memory request.
  always_comb begin
    state_nxt_s = state_r;
    req_s       = 1'b0;
    case (state_r)
      IDLE: begin
        req_s = req_i & space_s;
        if (req_s) begin
          state_nxt_s = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_GNT: begin
        req_s = 1'b1;
        if (instr_gnt_i) begin
          state_nxt_s = WAIT_RVALID;
        end else begin
          state_nxt_s = WAIT_GNT;
        end
      end
      WAIT_RVALID, WAIT_ABORTED: begin
        if (instr_rvalid_i) begin
          req_s = req_i & space_s;
          if (!req_s) begin
            state_nxt_s = IDLE;
          end else if (instr_gnt_i) begin
            state_nxt_s = WAIT_RVALID;
          end else begin
            state_nxt_s = WAIT_GNT;
          end
        end else if (redirect_s) begin
          req_s       = 1'b0;
          state_nxt_s = WAIT_ABORTED;
        end else begin
          req_s       = 1'b0;
          state_nxt_s = state_r;
        end
      end
      default: begin
        req_s       = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Next fetch address, program counter and hardware-loop flag.
  always_comb begin
    if (redirect_s) begin
      fetch_addr_nxt_s = {target_s[31:2], 2'b00};
    end else if (push_s) begin
      fetch_addr_nxt_s = fetch_addr_r + WORD_BYTES;
    end else begin
      fetch_addr_nxt_s = fetch_addr_r;
    end

    if (redirect_s) begin
      pc_nxt_s = target_s;
    end else if (consume_s) begin
      pc_nxt_s = pc_r + (is_32b(rdata_s[1:0]) ? WORD_BYTES : 32'd2);
    end else begin
      pc_nxt_s = pc_r;
    end

    if (branch_i) begin
      is_hwlp_nxt_s = 1'b0;
    end else if (hwlp_take_s) begin
      is_hwlp_nxt_s = 1'b1;
    end else if (consume_s) begin
      is_hwlp_nxt_s = 1'b0;
    end else begin
      is_hwlp_nxt_s = is_hwlp_r;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      fetch_addr_r <= 32'h0000_0000;
      pc_r         <= 32'h0000_0000;
      is_hwlp_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      fetch_addr_r <= fetch_addr_nxt_s;
      pc_r         <= pc_nxt_s;
      is_hwlp_r    <= is_hwlp_nxt_s;
    end
  end

  assign instr_req_o  = req_s;
  assign instr_addr_o = fetch_addr_nxt_s;
  assign rdata_o      = rdata_s;
  assign addr_o       = pc_r;
  assign is_hwlp_o    = is_hwlp_r & valid_o;
  assign busy_o       = req_s | (state_r != IDLE);

endmodule
